wb_timer: RTL and testbench

Wishbone pipelined-mode slave providing the machine timer and software-interrupt registers for the core. It sits on the data Wishbone bus directly downstream of the core's data-memory master, decodes single-word register accesses, and drives the core's `mtip_i` and `msip_i` interrupt inputs. It contains a 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a one-bit `msip` register.

---
 rtl/wb_timer.sv | 170 +++++++++++++++++
 tb/tb_wb_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer
// Description : Wishbone pipelined slave holding the 64-bit mtime counter with
//               prescaler, the 64-bit mtimecmp compare register and the msip
//               software-interrupt bit. Drives the core's mtip/msip inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer #(
    parameter int                    PRESCALE_W   = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] wb_dat_o,
    output logic        mtip_o,
    output logic        msip_o
);

    localparam logic [2:0] c_OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] c_OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] c_OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] c_OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] c_OFF_MSIP     = 3'd4;
    localparam logic [2:0] c_OFF_PRESCALE = 3'd5;
    localparam logic [PRESCALE_W-1:0] c_PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  msip_q, msip_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;
    logic                  mtip_q, mtip_d;

    logic        w_req;
    logic        w_mapped;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic [2:0]  w_off;
    logic [31:0] w_old;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic        w_unused_adr;

    // Only the word offset inside the block is decoded.
    assign w_unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign w_off        = wb_adr_i[4:2];
    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_mapped     = (w_off <= c_OFF_PRESCALE);
    // A write with no byte enabled is acked but must not disturb mtime ticking.
    assign w_wr         = w_req & wb_we_i & w_mapped & (wb_sel_i != 4'b0000);
    assign w_rd         = w_req & ~wb_we_i & w_mapped;
    assign w_tick       = (pcnt_q == prescale_q);

    // Current register contents at the addressed offset, and the bus read view
    // (offset 1 reads the shadow so a lo/hi read pair is coherent).
    always_comb begin
        w_old   = '0;
        w_rdata = '0;
        case (w_off)
            c_OFF_MTIME_LO: w_old = mtime_q[31:0];
            c_OFF_MTIME_HI: w_old = mtime_q[63:32];
            c_OFF_CMP_LO:   w_old = mtimecmp_q[31:0];
            c_OFF_CMP_HI:   w_old = mtimecmp_q[63:32];
            c_OFF_MSIP:     w_old[0] = msip_q;
            c_OFF_PRESCALE: w_old[PRESCALE_W-1:0] = prescale_q;
            default:        w_old = '0;
        endcase
        w_rdata = (w_off == c_OFF_MTIME_HI) ? hi_shadow_q : w_old;
    end

    // Byte-wise merge of write data onto the addressed register.
    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < 4; k++) begin
            if (wb_sel_i[k]) begin
                w_merged[8*k +: 8] = wb_dat_i[8*k +: 8];
            end
        end
    end

    // Next-state: prescaler/mtime advance, register writes, bus response.
    always_comb begin
        mtime_d     = w_tick ? (mtime_q + 64'd1) : mtime_q;
        pcnt_d      = w_tick ? '0 : (pcnt_q + c_PCNT_ONE);
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        prescale_d  = prescale_q;
        hi_shadow_d = hi_shadow_q;

        if (w_rd && (w_off == c_OFF_MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end

        if (w_wr) begin
            case (w_off)
                // A write to mtime overrides any tick in the same cycle.
                c_OFF_MTIME_LO: mtime_d = {mtime_q[63:32], w_merged};
                c_OFF_MTIME_HI: begin
                    mtime_d     = {w_merged, mtime_q[31:0]};
                    hi_shadow_d = w_merged;
                end
                c_OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], w_merged};
                c_OFF_CMP_HI:   mtimecmp_d = {w_merged, mtimecmp_q[31:0]};
                c_OFF_MSIP:     msip_d = w_merged[0];
                c_OFF_PRESCALE: begin
                    prescale_d = w_merged[PRESCALE_W-1:0];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end

        ack_d  = w_req & w_mapped;
        err_d  = w_req & ~w_mapped;
        dat_d  = w_rd ? w_rdata : '0;
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            prescale_q  <= PRESCALE_RST;
            pcnt_q      <= '0;
            hi_shadow_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            mtip_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            prescale_q  <= prescale_d;
            pcnt_q      <= pcnt_d;
            hi_shadow_q <= hi_shadow_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            mtip_q      <= mtip_d;
        end
    end

    // A master that drops cyc gets no response for the outstanding request.
    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_err_o   = err_q & wb_cyc_i;
    assign wb_dat_o   = wb_ack_o ? dat_q : '0;
    assign mtip_o     = mtip_q;
    assign msip_o     = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_timer
// Description : Directed self-checking bench for wb_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timer;

    logic        r_clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_cyc = 1'b0;
    logic        r_stb = 1'b0;
    logic        r_we  = 1'b0;
    logic [31:0] r_adr = '0;
    logic [31:0] r_dat = '0;
    logic [3:0]  r_sel = '0;
    logic        w_stall;
    logic        w_ack;
    logic        w_err;
    logic [31:0] w_dat;
    logic        w_mtip;
    logic        w_msip;

    int n_cmp = 0;
    int n_err = 0;

    wb_timer dut (
        .wb_clk_i   (r_clk),
        .wb_rst_i   (r_rst),
        .wb_cyc_i   (r_cyc),
        .wb_stb_i   (r_stb),
        .wb_we_i    (r_we),
        .wb_adr_i   (r_adr),
        .wb_dat_i   (r_dat),
        .wb_sel_i   (r_sel),
        .wb_stall_o (w_stall),
        .wb_ack_o   (w_ack),
        .wb_err_o   (w_err),
        .wb_dat_o   (w_dat),
        .mtip_o     (w_mtip),
        .msip_o     (w_msip)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns #1 after the accepting edge (response cycle).
    task automatic xfer(input logic we, input logic [2:0] off,
                        input logic [31:0] d, input logic [3:0] sel);
        r_cyc = 1'b1;
        r_stb = 1'b1;
        r_we  = we;
        r_adr = {27'h0, off, 2'b00};
        r_dat = d;
        r_sel = sel;
        @(posedge r_clk);
        #1;
        r_stb = 1'b0;
        r_we  = 1'b0;
        r_dat = '0;
        r_sel = '0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d,
                      input logic [3:0] sel, input string tag);
        xfer(1'b1, off, d, sel);
        chk({tag, "_ack"}, {63'b0, w_ack}, 64'd1);
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
        xfer(1'b0, off, 32'h0, 4'h0);
        chk({tag, "_ack"}, {63'b0, w_ack}, 64'd1);
        chk({tag, "_dat"}, {32'b0, w_dat}, {32'b0, exp});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    // Directed test sequence.
    initial begin
        repeat (2) @(posedge r_clk);
        #1;
        r_rst = 1'b0;

        // Reset state
        chk("rst_ack",   {63'b0, w_ack},   64'd0);
        chk("rst_err",   {63'b0, w_err},   64'd0);
        chk("rst_stall", {63'b0, w_stall}, 64'd0);
        chk("rst_dat",   {32'b0, w_dat},   64'd0);
        chk("rst_mtip",  {63'b0, w_mtip},  64'd0);
        chk("rst_msip",  {63'b0, w_msip},  64'd0);
        rd(3'd0, 32'h0000_0000, "rst_mtime_lo");
        rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(3'd5, 32'h0000_0000, "rst_prescale");

        // Prescale and wrap: second prescaler write aligns the counter phase
        wr(3'd5, 32'h0000_0003, 4'hF, "ps_wr");
        wr(3'd0, 32'hFFFF_FFFE, 4'hF, "mt_lo_wr");
        wr(3'd1, 32'hFFFF_FFFF, 4'hF, "mt_hi_wr");
        wr(3'd5, 32'h0000_0003, 4'hF, "ps_wr2");
        for (int k = 1; k <= 8; k++) begin
            rd(3'd0, (k <= 4) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, "ps_step");
        end
        // Shadow holds hi from the previous lo read even though mtime wrapped
        rd(3'd1, 32'hFFFF_FFFF, "coh_hi_pre_wrap");
        rd(3'd0, 32'h0000_0000, "wrap_lo");
        rd(3'd1, 32'h0000_0000, "wrap_hi");

        // Timer interrupt
        wr(3'd5, 32'h0000_0000, 4'hF, "ps_zero");
        wr(3'd2, 32'h0000_000A, 4'hF, "cmp_lo10");
        wr(3'd1, 32'h0000_0000, 4'hF, "mt_hi0");
        wr(3'd0, 32'h0000_0000, 4'hF, "mt_lo0");
        wr(3'd3, 32'h0000_0000, 4'hF, "cmp_hi0");
        chk("mtip_early", {63'b0, w_mtip}, 64'd0);
        cycles(9);
        chk("mtip_at_eq", {63'b0, w_mtip}, 64'd0);
        cycles(1);
        chk("mtip_rise", {63'b0, w_mtip}, 64'd1);
        wr(3'd3, 32'h0000_0001, 4'hF, "cmp_hi1");
        chk("mtip_hold", {63'b0, w_mtip}, 64'd1);
        cycles(1);
        chk("mtip_fall", {63'b0, w_mtip}, 64'd0);

        // Byte-enable write and software interrupt
        wr(3'd4, 32'h0000_0001, 4'b0001, "msip_set");
        chk("msip_set_o", {63'b0, w_msip}, 64'd1);
        wr(3'd4, 32'h0000_0000, 4'b0010, "msip_b1");
        chk("msip_keep_o", {63'b0, w_msip}, 64'd1);
        rd(3'd4, 32'h0000_0001, "msip_rd");
        wr(3'd4, 32'h0000_0000, 4'b0001, "msip_clr");
        chk("msip_clr_o", {63'b0, w_msip}, 64'd0);

        // Error path
        xfer(1'b0, 3'd6, 32'h0, 4'h0);
        chk("err_rd_err", {63'b0, w_err}, 64'd1);
        chk("err_rd_ack", {63'b0, w_ack}, 64'd0);
        chk("err_rd_dat", {32'b0, w_dat}, 64'd0);
        xfer(1'b1, 3'd6, 32'h1234_5679, 4'hF);
        chk("err_wr6_err", {63'b0, w_err}, 64'd1);
        xfer(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF);
        chk("err_wr7_err", {63'b0, w_err}, 64'd1);
        chk("err_wr7_ack", {63'b0, w_ack}, 64'd0);
        rd(3'd2, 32'h0000_000A, "err_keep_cmp_lo");
        rd(3'd3, 32'h0000_0001, "err_keep_cmp_hi");
        rd(3'd4, 32'h0000_0000, "err_keep_msip");
        rd(3'd5, 32'h0000_0000, "err_keep_ps");

        // Pipelining: back-to-back with cyc held, every request ticks mtime
        wr(3'd0, 32'h0000_1000, 4'hF, "pipe_mt_lo");
        wr(3'd2, 32'h0000_0055, 4'hF, "pipe_cmp_wr");
        rd(3'd2, 32'h0000_0055, "pipe_cmp_rd");
        rd(3'd0, 32'h0000_1002, "pipe_mt_rd");
        rd(3'd0, 32'h0000_1003, "pipe_mt_rd2");

        // Write coinciding with a tick loads exactly, no +1
        wr(3'd0, 32'h0000_2000, 4'hF, "tick_wr");
        rd(3'd0, 32'h0000_2000, "tick_rd");

        // Byte merge onto mtimecmp lo
        wr(3'd2, 32'hAABB_CCDD, 4'b1010, "merge_wr");
        rd(3'd2, 32'hAA00_CC55, "merge_rd");

        // Master drops cyc during the response cycle: no ack, write still lands
        xfer(1'b1, 3'd2, 32'h0000_0077, 4'hF);
        r_cyc = 1'b0;
        #1;
        chk("nocyc_ack", {63'b0, w_ack}, 64'd0);
        r_cyc = 1'b1;
        rd(3'd2, 32'h0000_0077, "nocyc_effect");

        // Reset asserted together with a write
        r_rst = 1'b1;
        xfer(1'b1, 3'd4, 32'h0000_0001, 4'hF);
        r_rst = 1'b0;
        chk("rstw_ack",  {63'b0, w_ack},  64'd0);
        chk("rstw_msip", {63'b0, w_msip}, 64'd0);
        rd(3'd2, 32'hFFFF_FFFF, "rstw_cmp_lo");
        rd(3'd4, 32'h0000_0000, "rstw_msip_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
